// File: rtl/reg_file_sb_pkg.sv
// Shared constants and types for the register file with scoreboard.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);
  localparam int unsigned REG_ZERO  = 0;

  typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// Read/write/issue bundle between the decode/writeback logic and the register file.
interface reg_file_sb_if
  import rf_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREGS = NREGS_DEF
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            WE;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic            issue_en;
  logic [AW-1:0]   issue_rd;
  logic            flush;
  logic            busy1;
  logic            busy2;
  logic            stall;

  modport master (
    output A1, A2, WE, A3, WD3, issue_en, issue_rd, flush,
    input  RD1, RD2, busy1, busy2, stall
  );

  modport slave (
    input  A1, A2, WE, A3, WD3, issue_en, issue_rd, flush,
    output RD1, RD2, busy1, busy2, stall
  );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit vector: flush clears everything, otherwise issue sets and writeback clears (set wins).
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned AW      = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  input  logic             flush,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_nxt;

  // Next busy vector with flush > set > clear priority.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (clr_en) busy_nxt[clr_idx] = 1'b0;
      if (set_en) busy_nxt[set_idx] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[REG_ZERO] = 1'b0;
  end

  // Busy vector register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file: two combinational reads, one write, optional x0 and bypass, hazard scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] busy;
  logic             we_eff;
  logic             hit1;
  logic             hit2;
  logic             hit_rd;
  logic             zero1;
  logic             zero2;

  rf_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (bus.issue_en),
    .set_idx (bus.issue_rd),
    .clr_en  (bus.WE),
    .clr_idx (bus.A3),
    .flush   (bus.flush),
    .busy    (busy)
  );

  // Storage array; writes to x0 are dropped when it is hardwired.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
    end else if (we_eff) begin
      mem[bus.A3] <= bus.WD3;
    end
  end

  // Write qualification and per-port forwarding matches.
  always_comb begin
    we_eff = bus.WE && !rst;
    if (ZERO_REG != 0 && bus.A3 == AW'(REG_ZERO)) we_eff = 1'b0;
    zero1  = (ZERO_REG != 0) && (bus.A1 == AW'(REG_ZERO));
    zero2  = (ZERO_REG != 0) && (bus.A2 == AW'(REG_ZERO));
    hit1   = (BYPASS != 0) && we_eff && (bus.A3 == bus.A1);
    hit2   = (BYPASS != 0) && we_eff && (bus.A3 == bus.A2);
    hit_rd = (BYPASS != 0) && bus.WE && (bus.A3 == bus.issue_rd);
  end

  // Read data, busy flags and stall.
  always_comb begin
    bus.RD1   = mem[bus.A1];
    bus.RD2   = mem[bus.A2];
    bus.busy1 = busy[bus.A1];
    bus.busy2 = busy[bus.A2];
    if (hit1) begin
      bus.RD1   = bus.WD3;
      bus.busy1 = 1'b0;
    end
    if (hit2) begin
      bus.RD2   = bus.WD3;
      bus.busy2 = 1'b0;
    end
    if (zero1) begin
      bus.RD1   = '0;
      bus.busy1 = 1'b0;
    end
    if (zero2) begin
      bus.RD2   = '0;
      bus.busy2 = 1'b0;
    end
    bus.stall = bus.busy1 | bus.busy2 | (bus.issue_en & busy[bus.issue_rd] & ~hit_rd);
  end

endmodule
